// File: rtl/seg_scan_driver.sv
// seg_scan_driver: self-scanning multiplexed seven-segment driver
// with a double-buffered image, per-digit blink/dp and grouped blanking.
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  power,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic [DIGITS-1:0]     group_in,
    input  logic                  lzb_in,
    output logic [DIGITS-1:0]     dis,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] GROUP_TOP = {1'b1, {(DIGITS-1){1'b0}}};

    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic          pending_q, pending_d;

    logic [DIGITS-1:0][3:0] sh_code_q, sh_code_d;
    logic [DIGITS-1:0]      sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]      sh_blink_q, sh_blink_d;
    logic [DIGITS-1:0]      sh_group_q, sh_group_d;
    logic                   sh_lzb_q, sh_lzb_d;

    logic [DIGITS-1:0][3:0] act_code_q, act_code_d;
    logic [DIGITS-1:0]      act_dp_q, act_dp_d;
    logic [DIGITS-1:0]      act_blink_q, act_blink_d;
    logic [DIGITS-1:0]      act_group_q, act_group_d;
    logic                   act_lzb_q, act_lzb_d;

    logic [DIGITS-1:0] dis_q, dis_d;
    logic [7:0]        seg_q, seg_d;
    logic              tick_q, tick_d;

    logic [DIGITS-1:0] zrun;
    logic [DIGITS-1:0] blank_v;
    logic              last_presc;
    logic              boundary;
    logic              commit;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            4'd10:   s = 7'b0000001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // zero run from each digit up to its group head; LSD of a group never blanks
    always_comb begin
        zrun = '0;
        zrun[DIGITS-1] = (act_code_q[DIGITS-1] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zrun[i] = (act_code_q[i] == 4'd0) && (act_group_q[i] || zrun[i+1]);
        end
        blank_v = {DIGITS{act_lzb_q}} & zrun & ~{act_group_q[DIGITS-2:0], 1'b1};
    end

    // scan timing, buffer commit, blink phase and registered pin image
    always_comb begin
        presc_d     = presc_q;
        scan_d      = scan_q;
        bcnt_d      = bcnt_q;
        phase_d     = phase_q;
        pending_d   = pending_q;
        sh_code_d   = sh_code_q;
        sh_dp_d     = sh_dp_q;
        sh_blink_d  = sh_blink_q;
        sh_group_d  = sh_group_q;
        sh_lzb_d    = sh_lzb_q;
        act_code_d  = act_code_q;
        act_dp_d    = act_dp_q;
        act_blink_d = act_blink_q;
        act_group_d = act_group_q;
        act_lzb_d   = act_lzb_q;
        dis_d       = '1;
        seg_d       = '0;

        last_presc = (presc_q == PRESC_MAX);
        boundary   = last_presc && (scan_q == SCAN_MAX);
        // with the display off there is no scan to wait for
        commit     = pending_q && (power ? boundary : 1'b1);
        tick_d     = commit;

        if (commit) begin
            act_code_d  = sh_code_q;
            act_dp_d    = sh_dp_q;
            act_blink_d = sh_blink_q;
            act_group_d = sh_group_q;
            act_lzb_d   = sh_lzb_q;
            pending_d   = 1'b0;
        end

        // a load on the commit cycle stays pending for the next frame
        if (load) begin
            sh_code_d  = digits_in;
            sh_dp_d    = dp_in;
            sh_blink_d = blink_in;
            sh_group_d = group_in | GROUP_TOP;
            sh_lzb_d   = lzb_in;
            pending_d  = 1'b1;
        end

        if (!power) begin
            presc_d = '0;
            scan_d  = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else begin
            presc_d = last_presc ? '0 : presc_q + 1'b1;
            if (last_presc) begin
                scan_d = boundary ? '0 : scan_q + 1'b1;
            end
            if (boundary) begin
                if (bcnt_q == BLINK_MAX) begin
                    bcnt_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            seg_d = {blank_v[scan_q] ? 7'b0 : seg_decode(act_code_q[scan_q]),
                     act_dp_q[scan_q]};
            if (!(phase_q && act_blink_q[scan_q])) begin
                dis_d[scan_q] = 1'b0;
            end
        end
    end

    // state update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            scan_q      <= '0;
            bcnt_q      <= '0;
            phase_q     <= 1'b0;
            pending_q   <= 1'b0;
            sh_code_q   <= {DIGITS{4'hF}};
            sh_dp_q     <= '0;
            sh_blink_q  <= '0;
            sh_group_q  <= '0;
            sh_lzb_q    <= 1'b0;
            act_code_q  <= {DIGITS{4'hF}};
            act_dp_q    <= '0;
            act_blink_q <= '0;
            act_group_q <= '0;
            act_lzb_q   <= 1'b0;
            dis_q       <= '1;
            seg_q       <= '0;
            tick_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            scan_q      <= scan_d;
            bcnt_q      <= bcnt_d;
            phase_q     <= phase_d;
            pending_q   <= pending_d;
            sh_code_q   <= sh_code_d;
            sh_dp_q     <= sh_dp_d;
            sh_blink_q  <= sh_blink_d;
            sh_group_q  <= sh_group_d;
            sh_lzb_q    <= sh_lzb_d;
            act_code_q  <= act_code_d;
            act_dp_q    <= act_dp_d;
            act_blink_q <= act_blink_d;
            act_group_q <= act_group_d;
            act_lzb_q   <= act_lzb_d;
            dis_q       <= dis_d;
            seg_q       <= seg_d;
            tick_q      <= tick_d;
        end
    end

    assign dis        = dis_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;

endmodule
